// File: rtl/mult_sequencer.sv
// Operand-pair queue that feeds an external sequential multiplier,
// collects its product (or a timeout error) and holds it for the consumer.
module mult_sequencer #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [31:0] In_multiplicand,
    input  logic [31:0] In_multiplier,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [63:0] Out_product,
    output logic        Out_error,
    output logic [31:0] Mul_multiplicand,
    output logic [31:0] Mul_multiplier,
    output logic        Mul_run,
    output logic        Mul_reset,
    input  logic [63:0] Mul_product,
    input  logic        Mul_ready,
    output logic        Busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   fifo_a [DEPTH];
    logic [31:0]   fifo_b [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic [TW-1:0] cyc_q;

    logic push, pop;
    logic done_ok, done_to;
    logic head_live;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign In_ready  = (count_q < CW'(DEPTH)) && !Reset;
    assign push      = In_valid && In_ready;
    assign pop       = done_ok || done_to;
    assign head_live = (state_q == LOAD) || (state_q == RUN);

    assign Busy      = (state_q != IDLE);
    assign Mul_run   = (state_q == RUN);
    assign Mul_reset = Reset || (state_q == LOAD);

    assign Mul_multiplicand = head_live ? fifo_a[rd_ptr] : '0;
    assign Mul_multiplier   = head_live ? fifo_b[rd_ptr] : '0;

    always_comb begin
        state_d = state_q;
        done_ok = 1'b0;
        done_to = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = LOAD;
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                // cyc_q == 0 marks the first RUN cycle, where Mul_ready is stale
                if (cyc_q != '0 && Mul_ready) begin
                    done_ok = 1'b1;
                    state_d = HOLD;
                end else if (cyc_q == TW'(TIMEOUT - 1)) begin
                    done_to = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Out_valid && Out_ready)
                    state_d = (count_q != '0) ? LOAD : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            cyc_q       <= '0;
            Out_valid   <= 1'b0;
            Out_error   <= 1'b0;
            Out_product <= '0;
        end else begin
            state_q <= state_d;

            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);

            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (state_q == LOAD)
                cyc_q <= '0;
            else if (state_q == RUN)
                cyc_q <= cyc_q + TW'(1);

            if (done_ok) begin
                Out_product <= Mul_product;
                Out_error   <= 1'b0;
                Out_valid   <= 1'b1;
            end else if (done_to) begin
                Out_product <= '0;
                Out_error   <= 1'b1;
                Out_valid   <= 1'b1;
            end else if (state_q == HOLD && Out_valid && Out_ready) begin
                Out_valid <= 1'b0;
                Out_error <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= In_multiplicand;
            fifo_b[wr_ptr] <= In_multiplier;
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: a queue-based reference model checked
// every cycle, plus literal expectations on the collected results.
module tb_mult_sequencer;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        Reset;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] In_multiplicand;
    logic [31:0] In_multiplier;
    logic        Out_valid;
    logic        Out_ready;
    logic [63:0] Out_product;
    logic        Out_error;
    logic [31:0] Mul_multiplicand;
    logic [31:0] Mul_multiplier;
    logic        Mul_run;
    logic        Mul_reset;
    logic [63:0] Mul_product;
    logic        Mul_ready;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .In_valid         (In_valid),
        .In_ready         (In_ready),
        .In_multiplicand  (In_multiplicand),
        .In_multiplier    (In_multiplier),
        .Out_valid        (Out_valid),
        .Out_ready        (Out_ready),
        .Out_product      (Out_product),
        .Out_error        (Out_error),
        .Mul_multiplicand (Mul_multiplicand),
        .Mul_multiplier   (Mul_multiplier),
        .Mul_run          (Mul_run),
        .Mul_reset        (Mul_reset),
        .Mul_product      (Mul_product),
        .Mul_ready        (Mul_ready),
        .Busy             (Busy)
    );

    // Stand-in multiplier: ready once it has seen mul_lat run cycles.
    int mul_lat = 3;
    int mul_cnt = 0;
    always @(posedge clk) begin
        if (Mul_reset)    mul_cnt <= 0;
        else if (Mul_run) mul_cnt <= mul_cnt + 1;
    end
    assign Mul_ready   = (mul_lat >= 0) && (mul_cnt >= mul_lat);
    assign Mul_product = {32'b0, Mul_multiplicand} * {32'b0, Mul_multiplier};

    task automatic check(input string name, input logic [64:0] act,
                         input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending pairs in a queue, phase of the current job.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HOLD = 3;

    pair_t       mq[$];
    int          m_phase = P_IDLE;
    int          m_run   = 0;
    logic        m_ov    = 1'b0;
    logic        m_oe    = 1'b0;
    logic [63:0] m_op    = '0;
    bit          m_push;
    int          m_sz;

    always @(posedge clk) begin
        m_push = In_valid && !Reset && (mq.size() < DEPTH);
        m_sz   = mq.size();
        if (Reset) begin
            mq.delete();
            m_phase = P_IDLE;
            m_run   = 0;
            m_ov    = 1'b0;
            m_oe    = 1'b0;
            m_op    = '0;
        end else begin
            case (m_phase)
                P_IDLE: if (m_sz > 0) m_phase = P_LOAD;
                P_LOAD: begin
                    m_phase = P_RUN;
                    m_run   = 0;
                end
                P_RUN: begin
                    m_run++;
                    if (m_run > 1 && Mul_ready) begin
                        m_op = {32'b0, mq[0].a} * {32'b0, mq[0].b};
                        m_oe = 1'b0;
                        m_ov = 1'b1;
                        void'(mq.pop_front());
                        m_phase = P_HOLD;
                    end else if (m_run == TIMEOUT) begin
                        m_op = '0;
                        m_oe = 1'b1;
                        m_ov = 1'b1;
                        void'(mq.pop_front());
                        m_phase = P_HOLD;
                    end
                end
                default: if (Out_ready) begin
                    m_ov    = 1'b0;
                    m_oe    = 1'b0;
                    m_phase = (mq.size() > 0) ? P_LOAD : P_IDLE;
                end
            endcase
            if (m_push) mq.push_back({In_multiplicand, In_multiplier});
        end
    end

    bit          chk_on = 1'b0;
    logic [64:0] res_q[$];
    int          mr_len = 0, last_mr_len = 0;
    int          run_len = 0, last_run_len = 0;
    logic        e_live;

    always @(negedge clk) begin
        if (chk_on) begin
            e_live = (m_phase == P_LOAD) || (m_phase == P_RUN);
            check("in_ready", In_ready, !Reset && (mq.size() < DEPTH));
            check("busy", Busy, m_phase != P_IDLE);
            check("mul_run", Mul_run, m_phase == P_RUN);
            check("mul_reset", Mul_reset, Reset || (m_phase == P_LOAD));
            check("mul_a", Mul_multiplicand, e_live ? mq[0].a : 32'd0);
            check("mul_b", Mul_multiplier, e_live ? mq[0].b : 32'd0);
            check("out_valid", Out_valid, m_ov);
            check("out_error", Out_error, m_oe);
            check("out_product", Out_product, m_op);

            if (Out_valid && Out_ready) res_q.push_back({Out_error, Out_product});
            if (!Reset) begin
                if (Mul_reset) mr_len++;
                else if (mr_len > 0) begin
                    last_mr_len = mr_len;
                    mr_len = 0;
                end
                if (Mul_run) run_len++;
                else if (run_len > 0) begin
                    last_run_len = run_len;
                    run_len = 0;
                end
            end else begin
                mr_len  = 0;
                run_len = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit acc;
        int g;
        acc = 1'b0;
        g = 0;
        In_valid = 1'b1;
        In_multiplicand = a;
        In_multiplier = b;
        while (!acc && g < 300) begin
            @(negedge clk);
            acc = In_ready;
            @(posedge clk);
            #2;
            g++;
        end
        if (!acc) begin
            n_fail++;
            $display("FAIL push_timeout: pair %h,%h not accepted", a, b);
        end
        In_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int g;
        g = 0;
        while (res_q.size() < n && g < budget) begin
            step(1);
            g++;
        end
        check("result_count", res_q.size(), n);
    endtask

    task automatic wait_sig(input string name, ref logic sig, input int budget);
        int g;
        g = 0;
        while (sig !== 1'b1 && g < budget) begin
            step(1);
            g++;
        end
        check(name, sig, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n0;

    initial begin
        Reset = 1'b1;
        In_valid = 1'b0;
        In_multiplicand = '0;
        In_multiplier = '0;
        Out_ready = 1'b1;
        @(posedge clk);
        #2 chk_on = 1'b1;
        step(1);
        @(negedge clk);
        check("rst_in_ready", In_ready, 1'b0);
        check("rst_mul_reset", Mul_reset, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_mul_run", Mul_run, 1'b0);
        check("rst_mul_a", Mul_multiplicand, 32'd0);
        check("rst_out_valid", Out_valid, 1'b0);
        @(posedge clk);
        #2 Reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", In_ready, 1'b1);
        check("post_rst_mul_reset", Mul_reset, 1'b0);
        step(1);

        // 3 x 5
        mul_lat = 3;
        push(32'd3, 32'd5);
        wait_results(1, 100);
        check("res_3x5", res_q[0], {1'b0, 64'd15});
        check("load_pulse_len", last_mr_len, 1);
        check("run_len_lat3", last_run_len, 4);
        step(2);

        // full-scale operands
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_results(2, 100);
        check("res_max", res_q[1], {1'b0, 64'hFFFF_FFFE_0000_0001});
        step(2);

        // back-pressure fills the queue
        Out_ready = 1'b0;
        push(32'd2, 32'd7);
        push(32'd4, 32'd9);
        push(32'd6, 32'd11);
        @(negedge clk);
        check("full_in_ready", In_ready, 1'b0);
        check("full_out_valid", Out_valid, 1'b1);
        step(5);
        Out_ready = 1'b1;
        wait_results(5, 300);
        check("drain0", res_q[2], {1'b0, 64'd14});
        check("drain1", res_q[3], {1'b0, 64'd36});
        check("drain2", res_q[4], {1'b0, 64'd66});
        step(2);

        // timeout, then a normal job
        mul_lat = -1;
        push(32'd9, 32'd9);
        push(32'd5, 32'd6);
        wait_results(6, 200);
        mul_lat = 2;
        check("timeout_res", res_q[5], {1'b1, 64'd0});
        check("timeout_run_len", last_run_len, TIMEOUT);
        wait_results(7, 100);
        check("after_timeout", res_q[6], {1'b0, 64'd30});
        check("run_len_lat2", last_run_len, 3);
        step(2);

        // reset mid-run with one pair queued
        mul_lat = -1;
        push(32'd1, 32'd2);
        push(32'd3, 32'd4);
        wait_sig("reach_run", Mul_run, 20);
        step(5);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_out_valid", Out_valid, 1'b0);
        check("mid_rst_mul_run", Mul_run, 1'b0);
        check("mid_rst_in_ready", In_ready, 1'b1);
        n0 = res_q.size();
        step(60);
        check("mid_rst_no_result", res_q.size(), n0);
        check("mid_rst_stays_idle", Busy, 1'b0);
        mul_lat = 3;

        // consumer stalls in HOLD
        Out_ready = 1'b0;
        mul_lat = 1;
        push(32'd100, 32'd200);
        wait_sig("hold_valid", Out_valid, 50);
        step(3);
        Out_ready = 1'b1;
        @(negedge clk);
        check("hold_product", Out_product, 64'd20000);
        @(posedge clk);
        #2 Out_ready = 1'b0;
        @(negedge clk);
        check("hold_released", Out_valid, 1'b0);
        Out_ready = 1'b1;
        check("hold_logged", res_q[n0], {1'b0, 64'd20000});
        step(3);

        // ready in first RUN cycle is ignored
        mul_lat = 0;
        push(32'd7, 32'd8);
        wait_results(n0 + 2, 100);
        check("res_lat0", res_q[n0+1], {1'b0, 64'd56});
        check("run_len_lat0", last_run_len, 2);
        step(3);

        // push lands on the pop edge
        mul_lat = 3;
        push(32'd10, 32'd10);
        step(5);
        push(32'd11, 32'd12);
        wait_results(n0 + 4, 200);
        check("simul_first", res_q[n0+2], {1'b0, 64'd100});
        check("simul_second", res_q[n0+3], {1'b0, 64'd132});
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
